// File: rtl/store_buffer_fwd.sv
// Store buffer between the cache stage and the data cache: holds speculative stores until the
// ROB commits them, drains committed stores in order and forwards store data to younger loads.
module store_buffer_fwd #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned SB_ENTRIES      = 4,
    parameter int unsigned ROB_ENTRY_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [WORD_SIZE-1:0]       alloc_addr,
    input  logic [WORD_SIZE-1:0]       alloc_data,
    input  logic [2:0]                 alloc_funct3,
    input  logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
    output logic                       full,
    output logic                       empty,
    input  logic                       rob_store_permission,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_sb_permission_rob_id,
    input  logic                       flush,
    output logic                       drain_valid,
    output logic [WORD_SIZE-1:0]       drain_addr,
    output logic [WORD_SIZE-1:0]       drain_data,
    output logic [WORD_SIZE/8-1:0]     drain_be,
    input  logic                       drain_ready,
    input  logic                       ld_valid,
    input  logic [WORD_SIZE-1:0]       ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       fwd_hit,
    output logic [WORD_SIZE-1:0]       fwd_data,
    output logic                       fwd_conflict
);
    localparam int unsigned NumLanes = WORD_SIZE / 8;
    localparam int unsigned OffW     = $clog2(NumLanes);
    localparam int unsigned PtrW     = $clog2(SB_ENTRIES);
    localparam int unsigned CntW     = PtrW + 1;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // Per-entry state
    logic [SB_ENTRIES-1:0]      valid_q, valid_d;
    logic [SB_ENTRIES-1:0]      committed_q, committed_d;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id_q [SB_ENTRIES];
    logic [WORD_SIZE-1:0]       addr_q   [SB_ENTRIES];
    logic [WORD_SIZE-1:0]       data_q   [SB_ENTRIES];
    logic [NumLanes-1:0]        be_q     [SB_ENTRIES];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] n_committed;

    logic                 alloc_accept;
    logic                 pop;
    logic [OffW-1:0]      alloc_off;
    logic [WORD_SIZE-1:0] alloc_word_addr;
    logic [WORD_SIZE-1:0] alloc_lane_data;
    logic [NumLanes-1:0]  alloc_be;

    logic [OffW-1:0]      ld_off;
    logic [NumLanes-1:0]  ld_mask;
    logic [WORD_SIZE-1:0] ld_word_addr;
    logic [PtrW-1:0]      scan_idx;
    logic                 found;
    logic [WORD_SIZE-1:0] sel_data;
    logic [NumLanes-1:0]  sel_be;
    logic [WORD_SIZE-1:0] ld_shifted;

    // Occupancy flags come from registered count only, so alloc_valid never reaches full.
    assign full         = (count_q == CntW'(SB_ENTRIES));
    assign empty        = (count_q == '0);
    assign alloc_accept = alloc_valid & ~full & ~flush;
    assign pop          = drain_valid & drain_ready;

    // Store lane encoding: data moved into its byte lanes, address reduced to the word.
    always_comb begin
        alloc_off       = alloc_addr[OffW-1:0];
        alloc_word_addr = {alloc_addr[WORD_SIZE-1:OffW], {OffW{1'b0}}};
        case (alloc_funct3)
            F3Byte: begin
                alloc_be        = NumLanes'(1) << alloc_off;
                alloc_lane_data = WORD_SIZE'(alloc_data[7:0]) << {alloc_off, 3'b000};
            end
            F3Half: begin
                alloc_be        = NumLanes'(3) << alloc_off;
                alloc_lane_data = WORD_SIZE'(alloc_data[15:0]) << {alloc_off, 3'b000};
            end
            F3Word: begin
                alloc_be        = '1;
                alloc_lane_data = alloc_data;
            end
            default: begin
                alloc_be        = '1;
                alloc_lane_data = alloc_data;
            end
        endcase
    end

    // Pointer, count and flag next-state. Permission is applied before flush so a store
    // granted in the flush cycle survives.
    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        n_committed = '0;

        if (rob_store_permission) begin
            for (int i = 0; i < SB_ENTRIES; i++) begin
                if (valid_q[i] && !committed_q[i] &&
                    rob_id_q[i] == rob_sb_permission_rob_id) begin
                    committed_d[i] = 1'b1;
                end
            end
        end

        if (pop) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            head_d              = head_q + PtrW'(1);
        end

        if (flush) begin
            // Committed entries form a contiguous prefix from head, so tail follows them.
            for (int i = 0; i < SB_ENTRIES; i++) begin
                valid_d[i]  = valid_d[i] & committed_d[i];
                n_committed = n_committed + CntW'(valid_d[i]);
            end
            tail_d  = head_d + n_committed[PtrW-1:0];
            count_d = n_committed;
        end else begin
            if (alloc_accept) begin
                valid_d[tail_q]     = 1'b1;
                committed_d[tail_q] = 1'b0;
                tail_d              = tail_q + PtrW'(1);
            end
            count_d = count_q + CntW'(alloc_accept) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            committed_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_ENTRIES; i++) begin
                rob_id_q[i] <= '0;
                addr_q[i]   <= '0;
                data_q[i]   <= '0;
                be_q[i]     <= '0;
            end
        end else if (alloc_accept) begin
            rob_id_q[tail_q] <= alloc_rob_id;
            addr_q[tail_q]   <= alloc_word_addr;
            data_q[tail_q]   <= alloc_lane_data;
            be_q[tail_q]     <= alloc_be;
        end
    end

    always_comb begin
        drain_valid = valid_q[head_q] & committed_q[head_q];
        drain_addr  = '0;
        drain_data  = '0;
        drain_be    = '0;
        if (drain_valid) begin
            drain_addr = addr_q[head_q];
            drain_data = data_q[head_q];
            drain_be   = be_q[head_q];
        end
    end

    // Forwarding: youngest overlapping entry decides between hit and conflict.
    always_comb begin
        ld_off       = ld_addr[OffW-1:0];
        ld_word_addr = {ld_addr[WORD_SIZE-1:OffW], {OffW{1'b0}}};
        case (ld_funct3)
            F3Byte, F3ByteU: ld_mask = NumLanes'(1) << ld_off;
            F3Half, F3HalfU: ld_mask = NumLanes'(3) << ld_off;
            default:         ld_mask = '1;
        endcase

        scan_idx = '0;
        found    = 1'b0;
        sel_data = '0;
        sel_be   = '0;
        for (int k = 0; k < SB_ENTRIES; k++) begin
            scan_idx = tail_q - PtrW'(k) - PtrW'(1);
            if (!found && valid_q[scan_idx] && addr_q[scan_idx] == ld_word_addr &&
                |(be_q[scan_idx] & ld_mask)) begin
                found    = 1'b1;
                sel_data = data_q[scan_idx];
                sel_be   = be_q[scan_idx];
            end
        end

        ld_shifted   = sel_data >> {ld_off, 3'b000};
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_data     = '0;
        if (ld_valid && found) begin
            if ((ld_mask & ~sel_be) == '0) begin
                fwd_hit = 1'b1;
                case (ld_funct3)
                    F3Byte:  fwd_data = {{(WORD_SIZE-8){ld_shifted[7]}}, ld_shifted[7:0]};
                    F3ByteU: fwd_data = WORD_SIZE'(ld_shifted[7:0]);
                    F3Half:  fwd_data = {{(WORD_SIZE-16){ld_shifted[15]}}, ld_shifted[15:0]};
                    F3HalfU: fwd_data = WORD_SIZE'(ld_shifted[15:0]);
                    default: fwd_data = ld_shifted;
                endcase
            end else begin
                fwd_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd: drain scoreboard fed at alloc time, directed forwarding checks.
module tb_store_buffer_fwd;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } drain_t;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [31:0] alloc_addr;
    logic [31:0] alloc_data;
    logic [2:0]  alloc_funct3;
    logic [2:0]  alloc_rob_id;
    logic        full;
    logic        empty;
    logic        rob_store_permission;
    logic [2:0]  rob_sb_permission_rob_id;
    logic        flush;
    logic        drain_valid;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_be;
    logic        drain_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_conflict;

    int     checks   = 0;
    int     failures = 0;
    drain_t drain_q[$];
    drain_t exp_drain;

    store_buffer_fwd #(
        .WORD_SIZE      (32),
        .SB_ENTRIES     (4),
        .ROB_ENTRY_WIDTH(3)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .alloc_valid             (alloc_valid),
        .alloc_addr              (alloc_addr),
        .alloc_data              (alloc_data),
        .alloc_funct3            (alloc_funct3),
        .alloc_rob_id            (alloc_rob_id),
        .full                    (full),
        .empty                   (empty),
        .rob_store_permission    (rob_store_permission),
        .rob_sb_permission_rob_id(rob_sb_permission_rob_id),
        .flush                   (flush),
        .drain_valid             (drain_valid),
        .drain_addr              (drain_addr),
        .drain_data              (drain_data),
        .drain_be                (drain_be),
        .drain_ready             (drain_ready),
        .ld_valid                (ld_valid),
        .ld_addr                 (ld_addr),
        .ld_funct3               (ld_funct3),
        .fwd_hit                 (fwd_hit),
        .fwd_data                (fwd_data),
        .fwd_conflict            (fwd_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic drain_t encode(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [2:0] f3);
        drain_t     e;
        logic [4:0] sh;
        sh     = {addr[1:0], 3'b000};
        e.addr = {addr[31:2], 2'b00};
        case (f3)
            3'b000: begin
                e.be   = 4'b0001 << addr[1:0];
                e.data = {24'h0, data[7:0]} << sh;
            end
            3'b001: begin
                e.be   = 4'b0011 << addr[1:0];
                e.data = {16'h0, data[15:0]} << sh;
            end
            default: begin
                e.be   = 4'hF;
                e.data = data;
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                         input logic [2:0] rob, input bit kept);
        alloc_valid  = 1'b1;
        alloc_addr   = addr;
        alloc_data   = data;
        alloc_funct3 = f3;
        alloc_rob_id = rob;
        if (kept) drain_q.push_back(encode(addr, data, f3));
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic permit(input logic [2:0] rob);
        rob_store_permission     = 1'b1;
        rob_sb_permission_rob_id = rob;
        tick();
        rob_store_permission = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic hit, input logic conf, input logic [31:0] data);
        ld_valid  = 1'b1;
        ld_addr   = addr;
        ld_funct3 = f3;
        #2;
        check_eq({tag, "_hit"}, 32'(fwd_hit), 32'(hit));
        check_eq({tag, "_conflict"}, 32'(fwd_conflict), 32'(conf));
        check_eq({tag, "_data"}, fwd_data, data);
        ld_valid = 1'b0;
        tick();
    endtask

    task automatic drain_all(input string tag);
        int n;
        n           = 0;
        drain_ready = 1'b1;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        drain_ready = 1'b0;
        check_eq(tag, 32'(empty), 32'd1);
    endtask

    // Every accepted drain handshake is compared against the oldest expected store.
    always @(negedge clk) begin
        if (!rst && drain_valid && drain_ready) begin
            if (drain_q.size() == 0) begin
                check_eq("drain_extra", 32'(drain_q.size()), 32'd1);
            end else begin
                exp_drain = drain_q.pop_front();
                check_eq("drain_addr", drain_addr, exp_drain.addr);
                check_eq("drain_data", drain_data, exp_drain.data);
                check_eq("drain_be", 32'(drain_be), 32'(exp_drain.be));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_addr = '0; alloc_data = '0; alloc_funct3 = '0;
        alloc_rob_id = '0; rob_store_permission = 1'b0; rob_sb_permission_rob_id = '0;
        flush = 1'b0; drain_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_drain_valid", 32'(drain_valid), 32'd0);
        check_eq("rst_drain_addr", drain_addr, 32'd0);
        check_eq("rst_fwd_hit", 32'(fwd_hit), 32'd0);

        // Single word store: commit, then drain
        alloc(32'h100, 32'hDEADBEEF, 3'b010, 3'd2, 1'b1);
        check_eq("t1_empty", 32'(empty), 32'd0);
        check_eq("t1_uncommitted", 32'(drain_valid), 32'd0);
        permit(3'd2);
        check_eq("t1_drain_valid", 32'(drain_valid), 32'd1);
        check_eq("t1_drain_addr", drain_addr, 32'h100);
        check_eq("t1_drain_be", 32'(drain_be), 32'hF);
        check_eq("t1_drain_data", drain_data, 32'hDEADBEEF);
        drain_all("t1_drained");

        // Fill with byte stores, drop the fifth, drain in order
        for (int i = 0; i < 4; i++) begin
            alloc(32'h200 + 32'(i), 32'hA0 + 32'(i), 3'b000, 3'(i), 1'b1);
        end
        check_eq("t2_full", 32'(full), 32'd1);
        alloc(32'h204, 32'h55, 3'b000, 3'd4, 1'b0);
        check_eq("t2_still_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) permit(3'(i));
        drain_all("t2_drained");

        // Lane extraction and extension
        alloc(32'h300, 32'h80FF1234, 3'b010, 3'd5, 1'b1);
        ld_valid = 1'b0; ld_addr = 32'h300; ld_funct3 = 3'b010;
        #1;
        check_eq("ld_idle_hit", 32'(fwd_hit), 32'd0);
        check_eq("ld_idle_data", fwd_data, 32'd0);
        load("lb", 32'h303, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80);
        load("lbu", 32'h303, 3'b100, 1'b1, 1'b0, 32'h00000080);
        load("lhu", 32'h300, 3'b101, 1'b1, 1'b0, 32'h00001234);
        load("lh", 32'h302, 3'b001, 1'b1, 1'b0, 32'hFFFF80FF);
        load("miss", 32'h304, 3'b010, 1'b0, 1'b0, 32'h0);
        permit(3'd5);
        drain_all("t3_drained");

        // Youngest overlapping store wins
        alloc(32'h400, 32'h11, 3'b000, 3'd6, 1'b1);
        alloc(32'h400, 32'hAABBCCDD, 3'b010, 3'd7, 1'b1);
        load("young_lw", 32'h400, 3'b010, 1'b1, 1'b0, 32'hAABBCCDD);
        load("young_lb", 32'h400, 3'b000, 1'b1, 1'b0, 32'hFFFFFFDD);
        permit(3'd6);
        permit(3'd7);
        drain_all("t4a_drained");
        alloc(32'h400, 32'hAABBCCDD, 3'b010, 3'd0, 1'b1);
        alloc(32'h401, 32'h55, 3'b000, 3'd1, 1'b1);
        load("part_lw", 32'h400, 3'b010, 1'b0, 1'b1, 32'h0);
        load("part_lh", 32'h400, 3'b001, 1'b0, 1'b1, 32'h0);
        load("sb_lbu", 32'h401, 3'b100, 1'b1, 1'b0, 32'h55);
        load("old_lbu", 32'h402, 3'b100, 1'b1, 1'b0, 32'hBB);
        permit(3'd0);
        permit(3'd1);
        drain_all("t4b_drained");

        // Flush with same-cycle permission and a discarded alloc
        alloc(32'h500, 32'h51, 3'b010, 3'd1, 1'b1);
        alloc(32'h504, 32'h52, 3'b010, 3'd2, 1'b0);
        alloc(32'h508, 32'h53, 3'b010, 3'd3, 1'b0);
        alloc_valid = 1'b1; alloc_addr = 32'h700; alloc_data = 32'h77;
        alloc_funct3 = 3'b010; alloc_rob_id = 3'd4;
        rob_store_permission = 1'b1; rob_sb_permission_rob_id = 3'd1; flush = 1'b1;
        tick();
        alloc_valid = 1'b0; rob_store_permission = 1'b0; flush = 1'b0;
        check_eq("fl_empty", 32'(empty), 32'd0);
        check_eq("fl_full", 32'(full), 32'd0);
        check_eq("fl_drain_valid", 32'(drain_valid), 32'd1);
        check_eq("fl_drain_addr", drain_addr, 32'h500);
        load("fl_gone2", 32'h504, 3'b010, 1'b0, 1'b0, 32'h0);
        load("fl_gone3", 32'h508, 3'b010, 1'b0, 1'b0, 32'h0);
        load("fl_no_alloc", 32'h700, 3'b010, 1'b0, 1'b0, 32'h0);
        alloc(32'h600, 32'h66, 3'b010, 3'd4, 1'b1);
        load("fl_new", 32'h600, 3'b010, 1'b1, 1'b0, 32'h66);
        permit(3'd4);
        drain_all("t5_drained");

        // Pop does not make room for a same-cycle alloc while full
        for (int i = 0; i < 4; i++) begin
            alloc(32'h800 + 32'(4 * i), 32'h1000 + 32'(i), 3'b010, 3'(i), 1'b1);
        end
        check_eq("t6_full", 32'(full), 32'd1);
        permit(3'd0);
        drain_ready = 1'b1;
        alloc_valid = 1'b1; alloc_addr = 32'h900; alloc_data = 32'h99;
        alloc_funct3 = 3'b010; alloc_rob_id = 3'd4;
        tick();
        drain_ready = 1'b0;
        alloc_valid = 1'b0;
        check_eq("t6_not_full", 32'(full), 32'd0);
        check_eq("t6_not_empty", 32'(empty), 32'd0);
        load("t6_dropped", 32'h900, 3'b010, 1'b0, 1'b0, 32'h0);
        load("t6_popped", 32'h800, 3'b010, 1'b0, 1'b0, 32'h0);
        permit(3'd1);
        permit(3'd2);
        drain_ready = 1'b1;
        tick();
        rst = 1'b1;
        drain_q.delete();
        tick();
        check_eq("rst2_empty", 32'(empty), 32'd1);
        check_eq("rst2_full", 32'(full), 32'd0);
        check_eq("rst2_drain_valid", 32'(drain_valid), 32'd0);
        check_eq("rst2_drain_addr", drain_addr, 32'd0);
        check_eq("rst2_drain_data", drain_data, 32'd0);
        check_eq("rst2_drain_be", 32'(drain_be), 32'd0);
        load("rst2_fwd", 32'h80C, 3'b010, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        drain_ready = 1'b0;
        tick();

        check_eq("sb_left", 32'(drain_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
